// File: rtl/pcihellocore_hex_pkg.sv
// Shared constants, state encoding and digit-select helper for the
// four-digit multiplexed seven-segment scanner.
package pcihellocore_hex_pkg;

    localparam int          NUM_DIGITS        = 4;
    localparam logic [31:0] HEX_RESET_WORD    = 32'h40404040;
    localparam logic [7:0]  HEX_BLANK_PATTERN = 8'hFF;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_e;

    // Active-low one-cold digit select for a digit index.
    function automatic logic [3:0] digit_select(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/pcihellocore_dwell_timer.sv
// Loadable down-counter with a registered done flag. done is high in the last
// cycle of a loaded interval; count==0 with done low means nothing is loaded.
module pcihellocore_dwell_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count,
    output logic         done
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            done  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            done  <= 1'b0;
        end else if (load) begin
            count <= load_value;
            done  <= (load_value == '0);
        end else if (count != '0) begin
            count <= count - W'(1);
            done  <= (count == W'(1));
        end else begin
            done  <= 1'b0;
        end
    end

endmodule

// File: rtl/pcihellocore_hex_scanner.sv
// Time-multiplexed scanner for four active-low seven-segment digits with
// blanking dead time between digits and a frame-latched shadow word.
module pcihellocore_hex_scanner
    import pcihellocore_hex_pkg::*;
#(
    parameter int          DWELL_CYCLES  = 50000,
    parameter int          BLANK_CYCLES  = 500,
    parameter logic [7:0]  BLANK_PATTERN = HEX_BLANK_PATTERN
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] seg_word,
    input  logic        enable,
    output logic [7:0]  seg,
    output logic [3:0]  dig_n,
    output logic        frame_done,
    output state_e      dbg_state,
    output logic [1:0]  dbg_idx,
    output logic [31:0] dbg_shadow
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] DRIVE_LOAD  = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LOAD  = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_FIRST = CW'((BLANK_CYCLES > 1) ? BLANK_CYCLES - 2 : 0);

    if (DWELL_CYCLES < 1 || BLANK_CYCLES < 1) begin : g_bad_params
        $error("pcihellocore_hex_scanner: DWELL_CYCLES and BLANK_CYCLES must be >= 1");
    end

    state_e          state, state_nx;
    logic [1:0]      idx, idx_nx;
    logic [31:0]     shadow, shadow_nx;
    logic [7:0]      seg_nx;
    logic [3:0]      dig_n_nx;
    logic            frame_done_nx;
    logic            tmr_clear, tmr_load, tmr_done, tmr_idle;
    logic [CW-1:0]   tmr_value, tmr_count;

    pcihellocore_dwell_timer #(.W(CW)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (tmr_clear),
        .load       (tmr_load),
        .load_value (tmr_value),
        .count      (tmr_count),
        .done       (tmr_done)
    );

    // Idle timer marks the first cycle of a BLANK entered from reset or disable.
    assign tmr_idle = (tmr_count == '0) && !tmr_done;

    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        shadow_nx     = shadow;
        frame_done_nx = 1'b0;
        tmr_clear     = 1'b0;
        tmr_load      = 1'b0;
        tmr_value     = '0;
        if (!enable) begin
            state_nx  = BLANK;
            idx_nx    = 2'd0;
            shadow_nx = seg_word;
            tmr_clear = 1'b1;
        end else begin
            case (state)
                BLANK: begin
                    if (tmr_done || (tmr_idle && BLANK_CYCLES == 1)) begin
                        state_nx  = DRIVE;
                        tmr_load  = 1'b1;
                        tmr_value = DRIVE_LOAD;
                    end else if (tmr_idle) begin
                        tmr_load  = 1'b1;
                        tmr_value = BLANK_FIRST;
                    end
                end
                DRIVE: begin
                    if (tmr_done) begin
                        state_nx  = BLANK;
                        idx_nx    = idx + 2'd1;
                        tmr_load  = 1'b1;
                        tmr_value = BLANK_LOAD;
                        if (idx == 2'(NUM_DIGITS - 1)) begin
                            shadow_nx     = seg_word;
                            frame_done_nx = 1'b1;
                        end
                    end
                end
                default: state_nx = BLANK;
            endcase
        end
        // Outputs are computed from the next state so they change on the transition edge.
        if (state_nx == DRIVE) begin
            seg_nx   = shadow_nx[{idx_nx, 3'b000} +: 8];
            dig_n_nx = digit_select(idx_nx);
        end else begin
            seg_nx   = BLANK_PATTERN;
            dig_n_nx = 4'hF;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= BLANK;
            idx        <= 2'd0;
            shadow     <= HEX_RESET_WORD;
            seg        <= BLANK_PATTERN;
            dig_n      <= 4'hF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            shadow     <= shadow_nx;
            seg        <= seg_nx;
            dig_n      <= dig_n_nx;
            frame_done <= frame_done_nx;
        end
    end

    assign dbg_state  = state;
    assign dbg_idx    = idx;
    assign dbg_shadow = shadow;

endmodule

// File: tb/tb_pcihellocore_hex_scanner.sv
// Directed bench for the hex scanner with DWELL_CYCLES=4, BLANK_CYCLES=2.
module tb_pcihellocore_hex_scanner;
    import pcihellocore_hex_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [31:0] seg_word;
    logic        enable;
    logic [7:0]  seg;
    logic [3:0]  dig_n;
    logic        frame_done;
    state_e      dbg_state;
    logic [1:0]  dbg_idx;
    logic [31:0] dbg_shadow;

    int checks = 0;
    int errors = 0;

    pcihellocore_hex_scanner #(
        .DWELL_CYCLES  (4),
        .BLANK_CYCLES  (2),
        .BLANK_PATTERN (8'hFF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .seg_word   (seg_word),
        .enable     (enable),
        .seg        (seg),
        .dig_n      (dig_n),
        .frame_done (frame_done),
        .dbg_state  (dbg_state),
        .dbg_idx    (dbg_idx),
        .dbg_shadow (dbg_shadow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check n consecutive cycles of one display phase, advancing a clock after each.
    task automatic phase(input string tag, input logic [3:0] dig, input logic [7:0] sg,
                         input int n, input bit fd_first);
        for (int i = 0; i < n; i++) begin
            check({tag, "_dig"}, 32'(dig_n), 32'(dig));
            check({tag, "_seg"}, 32'(seg), 32'(sg));
            check({tag, "_fd"}, 32'(frame_done), 32'(fd_first && i == 0));
            step();
        end
    endtask

    task automatic frame(input string tag, input logic [31:0] word, input bit fd_first);
        logic [3:0] sel [4];
        sel[0] = 4'hE; sel[1] = 4'hD; sel[2] = 4'hB; sel[3] = 4'h7;
        for (int d = 0; d < 4; d++) begin
            phase({tag, "_blank"}, 4'hF, 8'hFF, 2, fd_first && d == 0);
            phase({tag, "_drive"}, sel[d], word[8*d +: 8], 4, 1'b0);
        end
    endtask

    task automatic check_blank_state(input string tag, input logic [31:0] exp_shadow);
        check({tag, "_dig"}, 32'(dig_n), 32'h0000_000F);
        check({tag, "_seg"}, 32'(seg), 32'h0000_00FF);
        check({tag, "_fd"}, 32'(frame_done), 32'h0);
        check({tag, "_state"}, 32'(dbg_state), 32'(BLANK));
        check({tag, "_idx"}, 32'(dbg_idx), 32'h0);
        check({tag, "_shadow"}, dbg_shadow, exp_shadow);
    endtask

    // At most one digit active; seg may not change while the same digit stays driven.
    logic [3:0] prev_dig = 4'hF;
    logic [7:0] prev_seg = 8'hFF;
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            check("onehot_dig", 32'($countones(~dig_n) <= 1), 32'h1);
            if (prev_dig != 4'hF && dig_n == prev_dig)
                check("seg_steady", 32'(seg), 32'(prev_seg));
        end
        prev_dig = dig_n;
        prev_seg = seg;
    end

    initial begin
        reset_n  = 1'b1;
        enable   = 1'b1;
        seg_word = 32'h0;
        #2 reset_n = 1'b0;
        repeat (2) step();
        check_blank_state("reset", 32'h40404040);

        // Reset release: two blank clocks, then digit 0 of the reset word.
        reset_n = 1'b1;
        phase("rst_blank", 4'hF, 8'hFF, 2, 1'b0);
        phase("rst_d0", 4'hE, 8'h40, 4, 1'b0);

        // One-clock disable loads the shadow and restarts the frame.
        seg_word = 32'h79243019;
        enable   = 1'b0;
        step();
        check_blank_state("dis1", 32'h79243019);
        enable = 1'b1;
        frame("fa", 32'h79243019, 1'b0);

        // Second frame, seg_word cleared mid-digit-1: no tearing.
        phase("fb_b0", 4'hF, 8'hFF, 2, 1'b1);
        phase("fb_d0", 4'hE, 8'h19, 4, 1'b0);
        phase("fb_b1", 4'hF, 8'hFF, 2, 1'b0);
        phase("fb_d1a", 4'hD, 8'h30, 2, 1'b0);
        seg_word = 32'h0;
        phase("fb_d1b", 4'hD, 8'h30, 2, 1'b0);
        phase("fb_b2", 4'hF, 8'hFF, 2, 1'b0);
        phase("fb_d2", 4'hB, 8'h24, 4, 1'b0);
        phase("fb_b3", 4'hF, 8'hFF, 2, 1'b0);
        phase("fb_d3", 4'h7, 8'h79, 4, 1'b0);
        frame("fc", 32'h0, 1'b1);

        // Disable during digit 2.
        phase("fd_b0", 4'hF, 8'hFF, 2, 1'b1);
        phase("fd_d0", 4'hE, 8'h00, 4, 1'b0);
        phase("fd_b1", 4'hF, 8'hFF, 2, 1'b0);
        phase("fd_d1", 4'hD, 8'h00, 4, 1'b0);
        phase("fd_b2", 4'hF, 8'hFF, 2, 1'b0);
        phase("fd_d2", 4'hB, 8'h00, 2, 1'b0);
        enable   = 1'b0;
        seg_word = 32'h11223344;
        step();
        check_blank_state("dis2", 32'h11223344);
        phase("dis2_hold", 4'hF, 8'hFF, 3, 1'b0);
        enable = 1'b1;
        phase("en_blank", 4'hF, 8'hFF, 2, 1'b0);
        phase("en_d0", 4'hE, 8'h44, 4, 1'b0);
        phase("en_b1", 4'hF, 8'hFF, 2, 1'b0);
        phase("en_d1", 4'hD, 8'h33, 2, 1'b0);

        // Asynchronous reset between edges while digit 1 is driven.
        #2 reset_n = 1'b0;
        #1;
        check_blank_state("async_rst", 32'h40404040);
        step();
        reset_n = 1'b1;
        phase("rst2_blank", 4'hF, 8'hFF, 2, 1'b0);
        phase("rst2_d0", 4'hE, 8'h40, 4, 1'b0);
        phase("rst2_b1", 4'hF, 8'hFF, 2, 1'b0);
        phase("rst2_d1", 4'hD, 8'h40, 4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
